collision_checker: RTL and testbench
====================================

Name: collision_checker

Overview:
- Reads the enemy slot array that the obstacle generator writes each game frame, and the player's slot.
- Once per frame it scans every enemy slot sequentially and performs an axis-aligned bounding-box overlap test against the player.
- Produces a sticky game-over hit flag, the index of the first colliding slot, and a live-enemy count for the scoring and display logic.

Parameters:
- SLOTS, 4, number of enemy slots in the array (datacount - 1)
- TYPE_W, 2, slot type field width
- X_W, 10, x field width
- Y_W, 9, y field width
- W_W, 8, width field width
- H_W, 8, height field width
- DATALEN, 37, slot width: TYPE_W+X_W+Y_W+W_W+H_W

Ports:
- clk3  in  1  game clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  game running
- pause  in  1  game paused
- frame_tick  in  1  one-cycle pulse, request a scan
- clear_hit  in  1  synchronous clear of hit state
- gamedata  in  DATALEN*SLOTS  enemy slot array, slot i at [i*DATALEN +: DATALEN]
- playerdata  in  DATALEN  player slot, same layout
- hit  out  1  sticky collision flag
- hit_index  out  $clog2(SLOTS)  first colliding slot
- live_count  out  $clog2(SLOTS+1)  enemy-type slots found in last completed scan
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan end

Behaviour:
- Slot layout (LSB first): type [1:0], x [11:2], y [20:12], width [28:21], height [36:29].
- Type codes: null = 0, enemy = 1, player = 2.
- Reset (async, high): state IDLE; hit = 0, hit_index = 0, live_count = 0, busy = 0, scan_done = 0, idx = 0, internal count = 0.
- IDLE:
  - On frame_tick && start && !pause: latch the player x/y/width/height into a snapshot, idx = 0, count = 0, busy = 1, go to SCAN.
  - frame_tick under any other condition is ignored.
- SCAN: one slot per cycle; slot idx is read live from gamedata, not snapshotted.
  - A slot with type == enemy increments count.
  - Overlap test: ex < px+pw AND px < ex+ew AND ey < py+ph AND py < ey+eh.
  - Sums are computed one bit wider than the operands; there is no wrap-around.
  - Zero-width or zero-height enemies never overlap.
  - Enemy + overlap while hit == 0: set hit = 1 and hit_index = idx. The first hit wins; later hits in the same scan or later scans do not change hit_index.
  - When idx == SLOTS-1: go to DONE.
- DONE (one cycle): live_count = count (final count includes the last slot), scan_done = 1, busy = 0, go to IDLE.
- Latency: frame_tick to scan_done = SLOTS+1 cycles.
- pause high in SCAN: hold idx and count; no evaluation. Resume on pause low.
- start low in SCAN: abort to IDLE, busy = 0, no scan_done, live_count unchanged. hit is retained.
- frame_tick during SCAN or DONE is ignored; it is not queued.
- clear_hit:
  - Clears hit and hit_index in any state.
  - If asserted in the same cycle a hit is detected, the clear wins; the new hit is recorded on a later scan.
- Player snapshot is taken only at scan start; player changes mid-scan do not affect the current scan.

Decomposition:
- Add to shared define.v:
  - slot field offsets and widths
  - type codes: nulltype, enemytype, playertype
- Natural sub-module: aabb_overlap, combinational; two boxes in, overlap bit out, widened-sum comparisons. Instantiated once, muxed by idx.

Test Plan:
- Reset, then start = 1 with all slots null and frame_tick → scan_done 5 cycles later, live_count = 0, hit = 0.
- Player (x 50, y 100, w 20, h 30); slot 2 enemy (x 60, y 110, w 10, h 10); others null → hit = 1, hit_index = 2, live_count = 1.
- Edge touch: enemy x = 70 (= px + pw) → no hit. Enemy x = 69 → hit.
- Enemies colliding in slots 1 and 3 → hit_index = 1. A second scan leaves hit_index = 1. clear_hit → hit = 0, hit_index = 0.
- pause high for 3 cycles mid-scan → scan_done delayed by 3 cycles, counts unchanged. start low mid-scan → busy = 0, no scan_done pulse.
- Boundary: enemy x = 1023, w = 255 with player x = 1000 → hit, with no overflow from the widened sum. Async reset mid-scan → all outputs 0 immediately.

Source files
------------

// File: rtl/collision_checker_pkg.sv
// collision_checker_pkg
//   Shared slot layout for the game-frame data path. It holds the default
//   field widths and offsets, the slot type codes, the scan FSM state type
//   and a helper that sizes the widened coordinate sums.
package collision_checker_pkg;

  // Default slot field widths.
  localparam int TYPE_W_DEF = 2;
  localparam int X_W_DEF    = 10;
  localparam int Y_W_DEF    = 9;
  localparam int W_W_DEF    = 8;
  localparam int H_W_DEF    = 8;
  localparam int DATALEN_DEF = TYPE_W_DEF + X_W_DEF + Y_W_DEF + W_W_DEF + H_W_DEF;

  // Slot field offsets, LSB first: type, x, y, width, height.
  localparam int TYPE_OFF = 0;
  localparam int X_OFF    = TYPE_OFF + TYPE_W_DEF;
  localparam int Y_OFF    = X_OFF + X_W_DEF;
  localparam int W_OFF    = Y_OFF + Y_W_DEF;
  localparam int H_OFF    = W_OFF + W_W_DEF;

  // Slot type codes.
  localparam logic [1:0] NULLTYPE   = 2'd0;
  localparam logic [1:0] ENEMYTYPE  = 2'd1;
  localparam logic [1:0] PLAYERTYPE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Width of position+size sums: one bit wider than the wider operand, so
  // the sum never wraps.
  function automatic int sum_w(input int pos_w, input int size_w);
    return ((pos_w > size_w) ? pos_w : size_w) + 1;
  endfunction

endpackage

// File: rtl/collision_checker_aabb.sv
// aabb_overlap
//   Combinational axis-aligned bounding-box overlap test between one enemy
//   box (e*) and the player box (p*). Edges that only touch do not overlap.
//   A zero-width or zero-height enemy never overlaps.
// Ports:
//   ex, ey, ew, eh : enemy position and size
//   px, py, pw, ph : player position and size
//   overlap        : 1 when the two boxes intersect
module aabb_overlap
  import collision_checker_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int W_W = W_W_DEF,
  parameter int H_W = H_W_DEF
) (
  input  logic [X_W-1:0] ex,
  input  logic [Y_W-1:0] ey,
  input  logic [W_W-1:0] ew,
  input  logic [H_W-1:0] eh,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  input  logic [W_W-1:0] pw,
  input  logic [H_W-1:0] ph,
  output logic           overlap
);

  localparam int SXW = sum_w(X_W, W_W);
  localparam int SYW = sum_w(Y_W, H_W);

  logic [SXW-1:0] p_right, e_right;
  logic [SYW-1:0] p_bottom, e_bottom;

  always_comb begin
    p_right  = SXW'(px) + SXW'(pw);
    e_right  = SXW'(ex) + SXW'(ew);
    p_bottom = SYW'(py) + SYW'(ph);
    e_bottom = SYW'(ey) + SYW'(eh);
    overlap  = (ew != '0) && (eh != '0)
            && (SXW'(ex) < p_right) && (SXW'(px) < e_right)
            && (SYW'(ey) < p_bottom) && (SYW'(py) < e_bottom);
  end

endmodule

// File: rtl/collision_checker.sv
// collision_checker
//   Once per frame, scans the enemy slot array one slot per cycle and tests
//   each enemy against a snapshot of the player box. Keeps a sticky hit flag
//   with the first colliding slot and reports the live enemy count.
// Ports:
//   clk3       : game clock
//   reset      : asynchronous reset, active-high
//   start      : game running; dropping it aborts a scan in progress
//   pause      : game paused; freezes a scan in progress
//   frame_tick : one-cycle scan request (honoured only when idle)
//   clear_hit  : synchronous clear of hit/hit_index, wins over a new hit
//   gamedata   : enemy slots, slot i at [i*DATALEN +: DATALEN]
//   playerdata : player slot, same layout
//   hit        : sticky collision flag
//   hit_index  : first colliding slot
//   live_count : enemy-type slots seen in the last completed scan
//   busy       : scan in progress
//   scan_done  : one-cycle pulse when a scan completes
module collision_checker
  import collision_checker_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int W_W     = W_W_DEF,
  parameter int H_W     = H_W_DEF,
  parameter int DATALEN = TYPE_W + X_W + Y_W + W_W + H_W
) (
  input  logic                         clk3,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         frame_tick,
  input  logic                         clear_hit,
  input  logic [DATALEN*SLOTS-1:0]     gamedata,
  input  logic [DATALEN-1:0]           playerdata,
  output logic                         hit,
  output logic [$clog2(SLOTS)-1:0]     hit_index,
  output logic [$clog2(SLOTS+1)-1:0]   live_count,
  output logic                         busy,
  output logic                         scan_done
);

  localparam int IW  = $clog2(SLOTS);
  localparam int CW  = $clog2(SLOTS+1);
  localparam int XO  = TYPE_W;
  localparam int YO  = XO + X_W;
  localparam int WO  = YO + Y_W;
  localparam int HO  = WO + W_W;

  scan_state_t        state;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      count;
  logic [X_W-1:0]     snap_x;
  logic [Y_W-1:0]     snap_y;
  logic [W_W-1:0]     snap_w;
  logic [H_W-1:0]     snap_h;

  logic [DATALEN-1:0] slots [SLOTS];
  logic [DATALEN-1:0] slot;
  logic               is_enemy;
  logic               overlap;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign slots[g] = gamedata[g*DATALEN +: DATALEN];
  end

  // Slots are read live from gamedata; only the player is snapshotted.
  always_comb begin
    slot     = slots[idx];
    is_enemy = (slot[TYPE_W-1:0] == TYPE_W'(ENEMYTYPE));
  end

  aabb_overlap #(
    .X_W (X_W),
    .Y_W (Y_W),
    .W_W (W_W),
    .H_W (H_W)
  ) u_aabb (
    .ex      (slot[XO +: X_W]),
    .ey      (slot[YO +: Y_W]),
    .ew      (slot[WO +: W_W]),
    .eh      (slot[HO +: H_W]),
    .px      (snap_x),
    .py      (snap_y),
    .pw      (snap_w),
    .ph      (snap_h),
    .overlap (overlap)
  );

  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_w     <= '0;
      snap_h     <= '0;
      hit        <= 1'b0;
      hit_index  <= '0;
      live_count <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick && start && !pause) begin
            snap_x <= playerdata[XO +: X_W];
            snap_y <= playerdata[YO +: Y_W];
            snap_w <= playerdata[WO +: W_W];
            snap_h <= playerdata[HO +: H_W];
            idx    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (!start) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!pause) begin
            if (is_enemy) begin
              count <= count + 1'b1;
              if (overlap && !hit && !clear_hit) begin
                hit       <= 1'b1;
                hit_index <= idx;
              end
            end
            if (idx == IW'(SLOTS-1)) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          live_count <= count;
          scan_done  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Clear wins over any hit recorded in the same cycle.
      if (clear_hit) begin
        hit       <= 1'b0;
        hit_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_collision_checker.sv
module tb_collision_checker;
  localparam int SLOTS = 4;
  localparam int DL    = 37;

  logic                  clk3 = 1'b0;
  logic                  reset, start, pause, frame_tick, clear_hit;
  logic [DL*SLOTS-1:0]   gamedata;
  logic [DL-1:0]         playerdata;
  logic                  hit;
  logic [1:0]            hit_index;
  logic [2:0]            live_count;
  logic                  busy, scan_done;

  int tests = 0;
  int fails = 0;

  // Scene description and reference state.
  int et[SLOTS], ex[SLOTS], ey[SLOTS], ew[SLOTS], eh[SLOTS];
  int px, py, pw, ph;
  int m_hit, m_idx, m_live;

  collision_checker #(.SLOTS(SLOTS)) dut (
    .clk3       (clk3),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .frame_tick (frame_tick),
    .clear_hit  (clear_hit),
    .gamedata   (gamedata),
    .playerdata (playerdata),
    .hit        (hit),
    .hit_index  (hit_index),
    .live_count (live_count),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  always #5 clk3 = ~clk3;

  function automatic logic [DL-1:0] pack(input int t, input int x, input int y,
                                         input int w, input int h);
    logic [1:0] ft; logic [9:0] fx; logic [8:0] fy; logic [7:0] fw, fh;
    ft = t[1:0]; fx = x[9:0]; fy = y[8:0]; fw = w[7:0]; fh = h[7:0];
    return {fh, fw, fy, fx, ft};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < SLOTS; i++)
      gamedata[i*DL +: DL] = pack(et[i], ex[i], ey[i], ew[i], eh[i]);
    playerdata = pack(2, px, py, pw, ph);
  endtask

  task automatic set_slot(input int i, input int t, input int x, input int y,
                          input int w, input int h);
    et[i] = t; ex[i] = x; ey[i] = y; ew[i] = w; eh[i] = h;
  endtask

  task automatic null_all();
    for (int i = 0; i < SLOTS; i++) set_slot(i, 0, 0, 0, 0, 0);
  endtask

  // Reference: two intervals of positive length intersect on both axes.
  function automatic bit collides(input int i);
    if (et[i] != 1 || ew[i] == 0 || eh[i] == 0) return 0;
    return (ex[i] < px + pw) && (px < ex[i] + ew[i]) &&
           (ey[i] < py + ph) && (py < ey[i] + eh[i]);
  endfunction

  task automatic model_scan();
    int cnt, first;
    cnt = 0; first = -1;
    for (int i = 0; i < SLOTS; i++) begin
      if (et[i] == 1) cnt++;
      if (first < 0 && collides(i)) first = i;
    end
    m_live = cnt;
    if (m_hit == 0 && first >= 0) begin
      m_hit = 1; m_idx = first;
    end
  endtask

  // Issues one frame_tick and counts cycles until scan_done (bounded at 12).
  task automatic scan(input int pause_len, input bit mutate, input int clear_at,
                      input int abort_at, output int n);
    apply();
    @(negedge clk3) frame_tick = 1'b1;
    @(negedge clk3) frame_tick = 1'b0;
    n = 0;
    while (!scan_done && n < 12) begin
      pause     = (pause_len > 0 && n >= 1 && n < 1 + pause_len);
      clear_hit = (n == clear_at);
      if (n == abort_at) start = 1'b0;
      if (mutate && n == 1) playerdata = pack(2, 900, 400, 100, 100);
      @(negedge clk3);
      n++;
    end
    pause = 1'b0; clear_hit = 1'b0;
  endtask

  task automatic full(input string tag, input int pause_len, input bit mutate,
                      input int clear_at);
    int n;
    scan(pause_len, mutate, clear_at, -1, n);
    check({tag, ":latency"}, n, 5 + pause_len);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":hit"}, hit, m_hit);
    check({tag, ":hit_index"}, hit_index, m_idx);
    check({tag, ":live_count"}, live_count, m_live);
    @(negedge clk3);
    check({tag, ":done_pulse"}, scan_done, 0);
  endtask

  task automatic do_clear();
    @(negedge clk3) clear_hit = 1'b1;
    @(negedge clk3) clear_hit = 1'b0;
    m_hit = 0; m_idx = 0;
    check("clear:hit", hit, 0);
    check("clear:hit_index", hit_index, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; clear_hit = 1'b0;
    gamedata = '0; playerdata = '0;
    m_hit = 0; m_idx = 0; m_live = 0;
    null_all();
    px = 50; py = 100; pw = 20; ph = 30;
    repeat (2) @(negedge clk3);
    check("reset:hit", hit, 0);
    check("reset:hit_index", hit_index, 0);
    check("reset:live_count", live_count, 0);
    check("reset:busy", busy, 0);
    check("reset:scan_done", scan_done, 0);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk3);

    // Empty field.
    model_scan(); full("null", 0, 0, -1);

    // Single enemy inside the player box.
    set_slot(2, 1, 60, 110, 10, 10);
    model_scan(); full("single", 0, 0, -1);

    // Touching right edge does not collide, one pixel in does.
    do_clear();
    set_slot(2, 1, 70, 110, 10, 10);
    model_scan(); full("touch70", 0, 0, -1);
    set_slot(2, 1, 69, 110, 10, 10);
    model_scan(); full("touch69", 0, 0, -1);

    // First hit wins and persists across scans; player moved mid-scan.
    do_clear();
    null_all();
    set_slot(1, 1, 55, 105, 5, 5);
    set_slot(3, 1, 60, 110, 10, 10);
    model_scan(); full("first", 0, 0, -1);
    model_scan(); full("second", 0, 1, -1);
    do_clear();

    // Pause mid-scan stretches latency, count unaffected.
    set_slot(0, 1, 500, 300, 10, 10);
    set_slot(1, 2, 55, 105, 5, 5);
    set_slot(3, 0, 60, 110, 10, 10);
    model_scan(); full("pause", 3, 0, -1);

    // Degenerate enemies never collide.
    null_all();
    set_slot(0, 1, 55, 105, 0, 10);
    set_slot(2, 1, 55, 105, 10, 0);
    model_scan(); full("zero", 0, 0, -1);

    // Clear in the same cycle as a slot-0 hit; slot 3 then records.
    set_slot(0, 1, 60, 110, 10, 10);
    set_slot(2, 0, 0, 0, 0, 0);
    set_slot(3, 1, 52, 102, 4, 4);
    m_hit = 1; m_idx = 3; m_live = 2;
    full("clear_race", 0, 0, 0);
    do_clear();

    // Sums near the top of the coordinate range must not wrap.
    null_all();
    px = 1000; py = 100; pw = 30; ph = 30;
    set_slot(1, 1, 1023, 110, 255, 10);
    model_scan(); full("wide", 0, 0, -1);
    do_clear();
    px = 50; py = 100; pw = 20; ph = 30;

    // Abort: start dropped mid-scan, no pulse, live_count kept.
    set_slot(1, 1, 500, 10, 5, 5);
    scan(0, 0, -1, 2, n);
    check("abort:no_done", n, 12);
    check("abort:busy", busy, 0);
    check("abort:live_count", live_count, m_live);
    start = 1'b1;

    // frame_tick while paused in idle is ignored.
    pause = 1'b1;
    scan(0, 0, -1, -1, n);
    check("idle_pause:no_done", n, 12);
    check("idle_pause:busy", busy, 0);
    pause = 1'b0;

    // Randomized scenes around the player.
    for (int r = 0; r < 16; r++) begin
      px = 100 + $urandom_range(0, 700);
      py = 50 + $urandom_range(0, 350);
      pw = $urandom_range(0, 40);
      ph = $urandom_range(0, 40);
      for (int i = 0; i < SLOTS; i++)
        set_slot(i, $urandom_range(0, 2), px - 40 + $urandom_range(0, 80),
                 py - 40 + $urandom_range(0, 80), $urandom_range(0, 40),
                 $urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) do_clear();
      model_scan(); full("rand", 0, 0, -1);
    end

    // Async reset mid-scan clears everything without a clock edge.
    null_all();
    set_slot(0, 1, 60, 110, 10, 10);
    px = 50; py = 100; pw = 20; ph = 30;
    apply();
    @(negedge clk3) frame_tick = 1'b1;
    @(negedge clk3) frame_tick = 1'b0;
    @(negedge clk3);
    #2 reset = 1'b1;
    #1;
    check("areset:hit", hit, 0);
    check("areset:hit_index", hit_index, 0);
    check("areset:live_count", live_count, 0);
    check("areset:busy", busy, 0);
    check("areset:scan_done", scan_done, 0);
    @(negedge clk3) reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
